// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory and its program loader.
package imem_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      LOADING = 2'd1,
      FULL    = 2'd2
   } imem_state_t;

   // Instruction returned for out-of-range or misaligned fetches.
   localparam int unsigned NOP_INS = 0;

endpackage : imem_pkg

// File: rtl/imem_ram.sv
// Instruction store: one synchronous write port, one synchronous read port, no reset.
module imem_ram #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             rd_en_i,
   input  logic [AW-1:0]    rd_addr_i,
   output logic [WIDTH-1:0] rd_data_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] rd_data_q;

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
         rd_data_q <= mem_q[rd_addr_i];
      end
   end

   assign rd_data_o = rd_data_q;

endmodule : imem_ram

// File: rtl/imem_loader.sv
// Instruction memory with a sequential valid/ready program loader and a
// PC-addressed fetch port that is only serviced outside of load sessions.
module imem_loader
   import imem_pkg::*;
#(
   parameter int unsigned INS_WIDTH = 16,
   parameter int unsigned DEPTH     = 64,
   parameter int unsigned PC_WIDTH  = $clog2(DEPTH) + 1
) (
   input  logic                     clka,
   input  logic                     reset,
   input  logic                     we_ins,
   input  logic                     load_valid,
   input  logic [INS_WIDTH-1:0]     load,
   output logic                     load_ready,
   output logic [$clog2(DEPTH):0]   load_count,
   output logic                     overflow,
   input  logic                     fetch_en,
   input  logic [PC_WIDTH-1:0]      pc,
   output logic [INS_WIDTH-1:0]     instr,
   output logic                     instr_valid,
   output logic                     misaligned
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CNT_W = AW + 1;
   localparam int unsigned IDX_W = PC_WIDTH - 1;

   imem_state_t            state_q, state_d;
   logic [CNT_W-1:0]       count_q, count_d;
   logic                   ovf_q, ovf_d;
   logic                   ready_q, ready_d;
   logic                   wr_en_c;

   logic [IDX_W-1:0]       rd_idx_c;
   logic                   in_range_c;
   logic                   fetch_hit_c;
   logic                   rd_ok_c;
   logic [INS_WIDTH-1:0]   ram_rdata;

   logic                   fetch_q;
   logic                   ok_q;
   logic                   mis_q;
   logic [INS_WIDTH-1:0]   instr_q;
   logic                   instr_valid_q;
   logic                   mis_out_q;

   // Loader FSM: the word count doubles as the write pointer.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      wr_en_c = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (we_ins) begin
               state_d = LOADING;
               count_d = '0;
               ovf_d   = 1'b0;
            end
         end
         LOADING: begin
            if (!we_ins) begin
               state_d = IDLE;
            end else if (load_valid) begin
               wr_en_c = 1'b1;
               count_d = count_q + CNT_W'(1);
               if (count_q == CNT_W'(DEPTH - 1)) begin
                  state_d = FULL;
               end
            end
         end
         FULL: begin
            if (load_valid) begin
               ovf_d = 1'b1;
            end
            if (!we_ins) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      ready_d = (state_d == LOADING);
   end

   always_ff @(posedge clka) begin
      if (reset) begin
         state_q <= IDLE;
         count_q <= '0;
         ovf_q   <= 1'b0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         ready_q <= ready_d;
      end
   end

   // Fetch qualification uses the count before any same-edge session start.
   assign rd_idx_c    = pc[PC_WIDTH-1:1];
   assign in_range_c  = 32'(rd_idx_c) < 32'(count_q);
   assign fetch_hit_c = fetch_en & (state_q == IDLE);
   assign rd_ok_c     = fetch_hit_c & ~pc[0] & in_range_c;

   imem_ram #(
      .WIDTH (INS_WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk_i     (clka),
      .wr_en_i   (wr_en_c),
      .wr_addr_i (AW'(count_q)),
      .wr_data_i (load),
      .rd_en_i   (rd_ok_c),
      .rd_addr_i (AW'(rd_idx_c)),
      .rd_data_o (ram_rdata)
   );

   // Second stage turns the RAM read into a registered instruction or NOP.
   always_ff @(posedge clka) begin
      if (reset) begin
         fetch_q       <= 1'b0;
         ok_q          <= 1'b0;
         mis_q         <= 1'b0;
         instr_q       <= INS_WIDTH'(NOP_INS);
         instr_valid_q <= 1'b0;
         mis_out_q     <= 1'b0;
      end else begin
         fetch_q       <= fetch_hit_c;
         ok_q          <= rd_ok_c;
         mis_q         <= fetch_hit_c & pc[0];
         instr_valid_q <= fetch_q;
         if (fetch_q) begin
            instr_q   <= ok_q ? ram_rdata : INS_WIDTH'(NOP_INS);
            mis_out_q <= mis_q;
         end
      end
   end

   assign load_ready  = ready_q;
   assign load_count  = count_q;
   assign overflow    = ovf_q;
   assign instr       = instr_q;
   assign instr_valid = instr_valid_q;
   assign misaligned  = mis_out_q;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader against an array-based program-store model.
module tb_imem_loader;

   localparam int unsigned DEPTH = 8;
   localparam int unsigned CNT_W = 4;
   localparam int M_IDLE = 0;
   localparam int M_LOAD = 1;
   localparam int M_FULL = 2;
   localparam logic [15:0] PROG [6] = '{16'h1028, 16'h1261, 16'h9240, 16'h1261, 16'h1001, 16'h0000};

   logic        clka = 1'b0;
   logic        reset = 1'b1;
   logic        we_ins = 1'b0;
   logic        load_valid = 1'b0;
   logic [15:0] load = '0;
   logic        load_ready;
   logic [3:0]  load_count;
   logic        overflow;
   logic        fetch_en = 1'b0;
   logic [3:0]  pc = '0;
   logic [15:0] instr;
   logic        instr_valid;
   logic        misaligned;

   imem_loader #(
      .INS_WIDTH (16),
      .DEPTH     (DEPTH),
      .PC_WIDTH  (4)
   ) dut (
      .clka        (clka),
      .reset       (reset),
      .we_ins      (we_ins),
      .load_valid  (load_valid),
      .load        (load),
      .load_ready  (load_ready),
      .load_count  (load_count),
      .overflow    (overflow),
      .fetch_en    (fetch_en),
      .pc          (pc),
      .instr       (instr),
      .instr_valid (instr_valid),
      .misaligned  (misaligned)
   );

   always #5 clka = ~clka;

   int cyc = 0;
   always @(posedge clka) cyc++;

   typedef struct {
      int          due;
      logic [15:0] ins;
      logic        mis;
   } exp_t;

   exp_t        sb[$];
   int          tests = 0;
   int          fails = 0;

   // Reference model: session mode, program length, sticky overflow, and the store.
   int          m_state = M_IDLE;
   int          m_count = 0;
   bit          m_ovf = 1'b0;
   logic [15:0] m_mem [DEPTH];
   logic        cur_we = 1'b0;

   task automatic step(input logic r, input logic w, input logic lv, input logic [15:0] d,
                       input logic fe, input logic [3:0] p);
      exp_t e;
      int   idx;
      reset = r; we_ins = w; load_valid = lv; load = d; fetch_en = fe; pc = p;
      if (!r && m_state == M_IDLE && fe) begin
         idx   = int'(p) / 2;
         e.due = cyc + 2;
         if (p[0]) begin
            e.ins = 16'h0000; e.mis = 1'b1;
         end else if (idx < m_count) begin
            e.ins = m_mem[idx]; e.mis = 1'b0;
         end else begin
            e.ins = 16'h0000; e.mis = 1'b0;
         end
         sb.push_back(e);
      end
      @(posedge clka);
      if (r) begin
         m_state = M_IDLE; m_count = 0; m_ovf = 1'b0;
      end else begin
         case (m_state)
            M_IDLE: if (w) begin m_state = M_LOAD; m_count = 0; m_ovf = 1'b0; end
            M_LOAD: begin
               if (!w) m_state = M_IDLE;
               else if (lv) begin
                  m_mem[m_count] = d;
                  m_count++;
                  if (m_count == DEPTH) m_state = M_FULL;
               end
            end
            M_FULL: begin
               if (lv) m_ovf = 1'b1;
               if (!w) m_state = M_IDLE;
            end
            default: ;
         endcase
      end
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
   endtask

   task automatic load_words(input int n, input logic use_prog);
      step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
      for (int i = 0; i < n; i++)
         step(1'b0, 1'b1, 1'b1, use_prog ? PROG[i % 6] : 16'($urandom), 1'b0, 4'h0);
      step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
   endtask

   task automatic fetch(input logic [3:0] p);
      step(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, p);
   endtask

   task automatic do_reset();
      step(1'b0, cur_we, 1'b0, 16'h0, 1'b0, 4'h0);
      step(1'b0, cur_we, 1'b0, 16'h0, 1'b0, 4'h0);
      step(1'b1, cur_we, 1'b0, 16'h0, 1'b0, 4'h0);
   endtask

   // Monitor: status outputs every cycle, fetch results through the scoreboard.
   bit          rst_prev = 1'b0;
   logic [15:0] exp_last = 16'h0;
   always @(negedge clka) begin
      if (cyc >= 1) begin
         exp_t e;
         if (rst_prev) exp_last = 16'h0;
         rst_prev = reset;
         tests++;
         if (load_count !== CNT_W'(m_count)) begin
            fails++; $display("FAIL load_count @%0d: got %0d expected %0d", cyc, load_count, m_count);
         end
         tests++;
         if (load_ready !== (m_state == M_LOAD)) begin
            fails++; $display("FAIL load_ready @%0d: got %b expected %b", cyc, load_ready, m_state == M_LOAD);
         end
         tests++;
         if (overflow !== m_ovf) begin
            fails++; $display("FAIL overflow @%0d: got %b expected %b", cyc, overflow, m_ovf);
         end
         if (instr_valid === 1'b1) begin
            tests++;
            if (sb.size() == 0) begin
               fails++; $display("FAIL unexpected_fetch @%0d: got instr %h with no request pending", cyc, instr);
            end else begin
               e = sb.pop_front();
               exp_last = e.ins;
               if (instr !== e.ins || misaligned !== e.mis || cyc != e.due) begin
                  fails++;
                  $display("FAIL fetch @%0d: got instr %h mis %b expected instr %h mis %b due %0d",
                           cyc, instr, misaligned, e.ins, e.mis, e.due);
               end
            end
         end else begin
            tests++;
            if (instr !== exp_last) begin
               fails++; $display("FAIL instr_hold @%0d: got %h expected %h", cyc, instr, exp_last);
            end
            if (sb.size() != 0 && sb[0].due <= cyc) begin
               tests++; fails++;
               $display("FAIL missing_fetch @%0d: got instr_valid 0 expected instr %h", cyc, sb[0].ins);
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
      step(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
      idle(2);

      // 6-word program, then aligned, out-of-range and misaligned fetches
      load_words(6, 1'b1);
      fetch(4'd0); fetch(4'd2); fetch(4'd4); fetch(4'd12); fetch(4'd3); fetch(4'd10);
      idle(3);

      // Overfill: DEPTH+1 words, an extra offer while FULL, then read the last slot
      load_words(DEPTH + 1, 1'b0);
      idle(1);
      step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 1'b1, 16'($urandom), 1'b0, 4'h0);
      step(1'b0, 1'b1, 1'b1, 16'hDEAD, 1'b0, 4'h0);
      step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
      step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
      fetch(4'd14); fetch(4'd0); fetch(4'd15);
      idle(3);

      // Reset after 3 of 6 words; old contents unreachable; reload 2
      step(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 4'h0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, PROG[i], 1'b0, 4'h0);
      step(1'b1, 1'b1, 1'b1, PROG[3], 1'b0, 4'h0);
      step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
      fetch(4'd0); fetch(4'd2);
      load_words(2, 1'b0);
      for (int p = 0; p < 16; p += 2) fetch(4'(p));
      idle(3);

      // Fetch during LOADING is ignored; gapped valid gives exactly 2 writes
      step(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 4'h0);
      step(1'b0, 1'b1, 1'b1, 16'hA001, 1'b1, 4'h2);
      step(1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b1, 4'h4);
      step(1'b0, 1'b1, 1'b1, 16'hA002, 1'b1, 4'h6);
      step(1'b0, 1'b0, 1'b1, 16'hA003, 1'b1, 4'h8);
      fetch(4'd0); fetch(4'd2); fetch(4'd4);
      idle(3);

      // we_ins rising with a fetch in IDLE: fetch sees old word 0
      step(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 4'h0);
      step(1'b0, 1'b1, 1'b1, 16'hBEEF, 1'b0, 4'h0);
      step(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 4'h0);
      fetch(4'd0); fetch(4'd2);
      idle(3);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 199) == 0) do_reset();
         if ($urandom_range(0, 9) == 0) cur_we = ~cur_we;
         step(1'b0, cur_we, ($urandom_range(0, 9) < 6), 16'($urandom),
              ($urandom_range(0, 1) == 1), 4'($urandom_range(0, 15)));
      end
      cur_we = 1'b0;
      idle(4);

      tests++;
      if (sb.size() != 0) begin
         fails++; $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule : tb_imem_loader

// File: doc/imem_loader.md
# imem_loader

Parametrised instruction memory with an integrated sequential program loader, replacing the fixed 16-bit load path into the processor's instruction store. During load mode, instruction words are streamed in over a valid/ready port and written at auto-incrementing addresses. In run mode, the fetch stage reads instructions by byte-addressed PC. It sits between the external load interface and the fetch stage of `top_level`.

## Interface
Parameters:
- `INS_WIDTH`, 16, instruction word width in bits
- `DEPTH`, 64, number of instruction words (power of two, ≥ 2)
- `PC_WIDTH`, $clog2(DEPTH)+1, byte-address width (PC steps by 2 per instruction)

Ports:
- `clka`  in  1  single system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `we_ins`  in  1  load-mode request; level-sensitive
- `load_valid`  in  1  `load` holds a word to write
- `load`  in  INS_WIDTH  instruction word to write
- `load_ready`  out  1  loader accepts a word this cycle
- `load_count`  out  $clog2(DEPTH)+1  words written in the current or last load session
- `overflow`  out  1  sticky: a word was offered while the store was full
- `fetch_en`  in  1  fetch request
- `pc`  in  PC_WIDTH  byte address of the instruction to fetch
- `instr`  out  INS_WIDTH  fetched instruction
- `instr_valid`  out  1  `instr` is valid this cycle
- `misaligned`  out  1  the fetch that produced this `instr` had `pc[0]=1`

## Operation
- States: IDLE, LOADING, FULL.
- Reset values: state IDLE; `load_count`=0; `overflow`=0; `instr`=0; `instr_valid`=0; `misaligned`=0; `load_ready`=0.
- Memory contents are not reset.
- IDLE:
  - `we_ins`=1 → LOADING. Clears the write pointer, `load_count` and `overflow`.
  - Fetches are serviced.
- LOADING:
  - `load_ready`=1.
  - Transfer when `load_valid & load_ready`: write `mem[load_count] <= load`, then `load_count++`.
  - When a transfer makes `load_count`=DEPTH → FULL.
  - `we_ins`=0 → IDLE. `load_count` is kept as the program length.
- FULL:
  - `load_ready`=0.
  - `load_valid`=1 sets `overflow`. The word is dropped.
  - `we_ins`=0 → IDLE.
- Fetch (IDLE only):
  - Word index is `pc[PC_WIDTH-1:1]`.
  - Index < `load_count` and `pc[0]`=0 → `instr`=mem[index].
  - Index ≥ `load_count` → `instr`=0 (NOP).
  - `pc[0]`=1 → `instr`=0 and `misaligned`=1.
  - In all three cases `instr_valid`=1.
- A fetch request in LOADING or FULL is ignored: `instr_valid`=0, `instr` holds its value.
- `we_ins` is sampled every cycle. Deasserting it mid-load ends the session at the current count.

## Timing
- Load: one word per cycle at most. The write is visible to a fetch issued in the cycle after the session returns to IDLE.
- Fetch latency is 1 cycle. A request at edge N gives registered `instr`/`instr_valid`/`misaligned` after edge N+1.
- With no request, `instr_valid`=0 the next cycle and `instr` holds.
- Same cycle: `we_ins` rises while `fetch_en`=1 in IDLE → that fetch is serviced. State moves to LOADING at the same edge.
- `load_valid` in the same cycle LOADING exits → no write (`load_ready` is evaluated in the current state).
- Reset mid-load:
  - Next cycle: IDLE, `load_count`=0.
  - All fetches return NOP until a new load completes.
  - Old memory contents are unreachable.
- Write pointer wrap: cannot happen; FULL blocks writes at `load_count`=DEPTH.

## Structure
- Shared package `imem_pkg`:
  - state enum `imem_state_t` (IDLE, LOADING, FULL)
  - `NOP_INS` constant (all zeros)
- Sub-module `imem_ram` (DEPTH×INS_WIDTH, one synchronous write port, one synchronous read port, no reset).
- Loader FSM, count/overflow logic and fetch qualification live in `imem_loader`.

## Test plan
- Reset, then a 6-word load (16'h1028, 16'h1261, 16'h9240, 16'h1261, 16'h1001, 16'h0000) → `load_count`=6. Fetches at pc=0,2,4 return 16'h1028, 16'h1261, 16'h9240 one cycle later with `instr_valid`=1.
- Fetch pc=12 after the 6-word load → `instr`=0, `instr_valid`=1, `misaligned`=0. Fetch pc=3 → `instr`=0, `misaligned`=1.
- DEPTH=4: offer 5 words → `load_ready` drops after the 4th, `overflow`=1, `load_count`=4. pc=6 returns the 4th word.
- Assert `reset` after 3 of 6 words → `load_count`=0 next cycle. Fetch pc=0 returns 0. Reload 2 words → only pc=0 and pc=2 return data.
- `fetch_en` during LOADING → `instr_valid`=0 and `instr` unchanged. Gapped `load_valid` (1,0,1) → exactly 2 writes.
- `we_ins` and `fetch_en` asserted together in IDLE with pc=0 → the fetch returns the old word 0 and the state enters LOADING at the same edge.
